// File: rtl/axis_arb_mux.sv
// axis_arb_mux: N:1 AXI-stream arbiter/mux (fixed-priority or round-robin, tlast packet lock) with a 2-entry registered skid output.
// Optional idle-lock watchdog is compiled in by defining AXIS_ARB_MUX_TIMEOUT_EN.
module axis_arb_mux #(
  parameter int NUM_FANIN      = 6,
  parameter int DATA_WIDTH     = 256,
  parameter int USER_WIDTH     = 8,
  parameter int CHAN_WIDTH     = $clog2(NUM_FANIN),
  parameter int ARB_MODE       = 1,
  parameter int USE_AXIS_TLAST = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             s_axis_clk,
  input  logic                             s_axis_rst_n,
  input  logic [NUM_FANIN-1:0]             s_axis_tvalid,
  output logic [NUM_FANIN-1:0]             s_axis_tready,
  input  logic [NUM_FANIN*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_FANIN-1:0]             s_axis_tlast,
  input  logic [NUM_FANIN*USER_WIDTH-1:0]  s_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH+CHAN_WIDTH-1:0] m_axis_tuser,
  output logic [NUM_FANIN-1:0]             arb_timeout_err
);
  localparam int TW = USER_WIDTH + CHAN_WIDTH;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [CHAN_WIDTH-1:0] gnt_q, rr_ptr, arb_idx, gnt, gnt_nxt;
  logic arb_found, locked, gnt_vld, rdy_en, sp_vld, accept, pop, pkt_end, to_fire;
  logic in_last, sp_last;
  logic [DATA_WIDTH-1:0] tdata_a [NUM_FANIN];
  logic [USER_WIDTH-1:0] tuser_a [NUM_FANIN];
  logic [DATA_WIDTH-1:0] in_data, sp_data;
  logic [TW-1:0] in_user, sp_user;

  if (NUM_FANIN < 2 || NUM_FANIN > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axis_arb_mux: parameter out of range");
  end

  for (genvar i = 0; i < NUM_FANIN; i++) begin : g_unpack
    assign tdata_a[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign tuser_a[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
  end

  function automatic logic [CHAN_WIDTH-1:0] wrap_add(input logic [CHAN_WIDTH-1:0] b, input int k);
    int s = int'(b) + k;
    return CHAN_WIDTH'(s >= NUM_FANIN ? s - NUM_FANIN : s);
  endfunction

  // Mode 0: last hit in an upward scan is the highest index; mode 1: first hit from rr_ptr.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NUM_FANIN; k++) begin
      if (ARB_MODE == 0) begin
        if (s_axis_tvalid[k]) begin
          arb_idx   = CHAN_WIDTH'(k);
          arb_found = 1'b1;
        end
      end else if (!arb_found && s_axis_tvalid[wrap_add(rr_ptr, k)]) begin
        arb_idx   = wrap_add(rr_ptr, k);
        arb_found = 1'b1;
      end
    end
  end

  assign locked        = state == LOCK;
  assign gnt           = locked ? gnt_q : arb_idx;
  assign gnt_nxt       = wrap_add(gnt, 1);
  assign gnt_vld       = locked || arb_found;
  assign s_axis_tready = (rdy_en && gnt_vld && !sp_vld) ? NUM_FANIN'(1) << gnt : '0;
  assign accept        = |(s_axis_tready & s_axis_tvalid);
  assign in_data       = tdata_a[gnt];
  assign in_last       = s_axis_tlast[gnt];
  assign in_user       = {tuser_a[gnt], gnt};
  assign pkt_end       = accept && (USE_AXIS_TLAST == 0 || in_last);
  assign pop           = m_axis_tvalid && m_axis_tready;

`ifdef AXIS_ARB_MUX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  logic [TCW-1:0] idle_cnt;
  logic [NUM_FANIN-1:0] err_q;
  assign to_fire         = locked && !s_axis_tvalid[gnt_q] && idle_cnt == TCW'(TIMEOUT_CYCLES - 1);
  assign arb_timeout_err = err_q;
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      idle_cnt <= '0;
      err_q    <= '0;
    end else begin
      idle_cnt <= (!locked || accept || to_fire) ? '0 : idle_cnt + TCW'(!s_axis_tvalid[gnt_q]);
      if (to_fire) err_q[gnt_q] <= 1'b1;
    end
  end
`else
  assign to_fire         = 1'b0;
  assign arb_timeout_err = '0;
`endif

  // rdy_en keeps tready low through reset and the first cycle after release.
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      state         <= IDLE;
      gnt_q         <= '0;
      rr_ptr        <= '0;
      rdy_en        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      sp_vld        <= 1'b0;
      sp_data       <= '0;
      sp_last       <= 1'b0;
      sp_user       <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        gnt_q <= gnt;
        state <= (USE_AXIS_TLAST != 0 && !in_last) ? LOCK : IDLE;
      end else if (to_fire) begin
        state <= IDLE;
      end
      if (pkt_end || to_fire) rr_ptr <= gnt_nxt;
      if (sp_vld) begin
        if (pop) begin
          m_axis_tdata <= sp_data;
          m_axis_tlast <= sp_last;
          m_axis_tuser <= sp_user;
          sp_vld       <= 1'b0;
        end
      end else if (accept && (!m_axis_tvalid || pop)) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= in_data;
        m_axis_tlast  <= in_last;
        m_axis_tuser  <= in_user;
      end else if (accept) begin
        sp_vld  <= 1'b1;
        sp_data <= in_data;
        sp_last <= in_last;
        sp_user <= in_user;
      end else if (pop) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_arb_mux.sv
// tb_axis_arb_mux: randomized + directed bench for axis_arb_mux against a queue-based reference model.
module tb_axis_arb_mux;
  localparam int N = 6, DW = 32, UW = 8, CW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] tvalid, tready, tlast, err;
  logic [N*DW-1:0] tdata;
  logic [N*UW-1:0] tuser;
  logic m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [UW+CW-1:0] m_tuser;

  logic [N-1:0] f_tvalid, f_tready, f_tlast, f_err;
  logic [N*DW-1:0] f_tdata;
  logic [N*UW-1:0] f_tuser;
  logic f_m_tvalid, f_m_tready, f_m_tlast;
  logic [DW-1:0] f_m_tdata;
  logic [UW+CW-1:0] f_m_tuser;

  axis_arb_mux #(.NUM_FANIN(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ARB_MODE(1),
                 .USE_AXIS_TLAST(1), .TIMEOUT_CYCLES(8)) dut (
    .s_axis_clk(clk), .s_axis_rst_n(rst_n),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .arb_timeout_err(err));

  axis_arb_mux #(.NUM_FANIN(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ARB_MODE(0),
                 .USE_AXIS_TLAST(1), .TIMEOUT_CYCLES(8)) dut_fp (
    .s_axis_clk(clk), .s_axis_rst_n(rst_n),
    .s_axis_tvalid(f_tvalid), .s_axis_tready(f_tready), .s_axis_tdata(f_tdata),
    .s_axis_tlast(f_tlast), .s_axis_tuser(f_tuser),
    .m_axis_tvalid(f_m_tvalid), .m_axis_tready(f_m_tready), .m_axis_tdata(f_m_tdata),
    .m_axis_tlast(f_m_tlast), .m_axis_tuser(f_m_tuser), .arb_timeout_err(f_err));

  typedef struct packed {
    logic [DW-1:0]    d;
    logic             l;
    logic [UW+CW-1:0] u;
  } beat_t;

  int n_tests = 0, n_fail = 0;
  beat_t q[$];
  int tag_log[$];
  bit locked;
  int lock_ch, rr, mrate, out_beats;
  bit pv[N], pl[N];
  logic [DW-1:0] pd[N];
  logic [UW-1:0] pu[N];
  int left[N], en_rate[N], fix_len[N], hold[N];
  int rr_exp[6] = '{0, 2, 5, 0, 2, 5};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    locked = 0;
    lock_ch = 0;
    rr = 0;
    for (int c = 0; c < N; c++) begin
      pv[c] = 0; pl[c] = 0; pd[c] = '0; pu[c] = '0;
      left[c] = 0; en_rate[c] = 0; fix_len[c] = 0; hold[c] = 0;
    end
    tvalid = '0; tdata = '0; tlast = '0; tuser = '0;
  endtask

  // One clock: drive producers at negedge, compare DUT against the model, advance the model.
  task automatic step();
    int g, rate;
    bit gv, acc;
    logic [N-1:0] er;
    beat_t b;
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      rate = (en_rate[c] == 0 && left[c] > 0) ? 100 : en_rate[c];
      if (hold[c] > 0) hold[c]--;
      else if (!pv[c] && rate > 0 && $urandom_range(99) < rate) begin
        if (left[c] == 0) left[c] = fix_len[c] > 0 ? fix_len[c] : int'($urandom_range(1, 4));
        pv[c] = 1;
        pd[c] = $urandom;
        pu[c] = UW'($urandom);
        pl[c] = left[c] == 1;
      end
      tvalid[c] = pv[c];
      tlast[c] = pl[c];
      tdata[c*DW +: DW] = pd[c];
      tuser[c*UW +: UW] = pu[c];
    end
    m_tready = $urandom_range(99) < mrate;
    #1;
    gv = 0;
    g = 0;
    if (locked) begin
      g = lock_ch;
      gv = 1;
    end else begin
      for (int k = 0; k < N; k++)
        if (!gv && pv[(rr + k) % N]) begin
          g = (rr + k) % N;
          gv = 1;
        end
    end
    er = (gv && q.size() < 2) ? N'(1) << g : '0;
    check("s_tready", tready, er);
    check("m_tvalid", m_tvalid, q.size() > 0);
    if (q.size() > 0) begin
      check("m_tdata", m_tdata, q[0].d);
      check("m_tlast", m_tlast, q[0].l);
      check("m_tuser", m_tuser, q[0].u);
    end
    if (m_tvalid && m_tready) begin
      out_beats++;
      if (m_tlast) tag_log.push_back(int'(m_tuser[CW-1:0]));
    end
    acc = gv && q.size() < 2 && pv[g];
    if (q.size() > 0 && m_tready) void'(q.pop_front());
    if (acc) begin
      b.d = pd[g];
      b.l = pl[g];
      b.u = {pu[g], CW'(g)};
      q.push_back(b);
      pv[g] = 0;
      left[g]--;
      if (pl[g]) begin
        locked = 0;
        rr = (g + 1) % N;
      end else begin
        locked = 1;
        lock_ch = g;
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    bit busy = 1;
    for (int c = 0; c < N; c++) en_rate[c] = 0;
    while (busy && k < 300) begin
      step();
      k++;
      busy = q.size() > 0;
      for (int c = 0; c < N; c++) if (pv[c] || left[c] > 0) busy = 1;
    end
    check("drain_done", k < 300, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    m_tready = 0;
    f_m_tready = 0;
    f_tvalid = '0; f_tdata = '0; f_tlast = '0; f_tuser = '0;
    mrate = 100;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", m_tuser, 0);
    check("rst_tready", tready, 0);
    rst_n = 1;
    // Round-robin over channels 0,2,5 with back-to-back 3-beat packets.
    for (int c = 0; c < N; c += 1) if (c == 0 || c == 2 || c == 5) begin
      en_rate[c] = 100;
      fix_len[c] = 3;
    end
    tag_log.delete();
    out_beats = 0;
    repeat (19) step();
    check("rr_throughput", out_beats, 18);
    for (int i = 0; i < 6; i++) check("rr_order", tag_log.size() > i ? tag_log[i] : 99, rr_exp[i]);
    drain();
    for (int c = 0; c < N; c++) fix_len[c] = 0;
    // Locked channel 3 stalls 5 cycles mid-packet while channel 0 waits.
    tag_log.delete();
    en_rate[3] = 100;
    fix_len[3] = 4;
    step();
    en_rate[3] = 0;
    hold[3] = 5;
    en_rate[0] = 100;
    fix_len[0] = 2;
    repeat (5) begin
      step();
      check("lock_block", tready[0], 0);
    end
    repeat (4) step();
    drain();
    check("lock_order0", tag_log.size() > 0 ? tag_log[0] : 99, 3);
    check("lock_order1", tag_log.size() > 1 ? tag_log[1] : 99, 0);
    for (int c = 0; c < N; c++) fix_len[c] = 0;
    // Random traffic with a 50% output stall rate.
    for (int c = 0; c < N; c++) en_rate[c] = 50;
    mrate = 50;
    out_beats = 0;
    k = 0;
    while (out_beats < 1000 && k < 20000) begin
      step();
      k++;
    end
    check("rand_done", out_beats >= 1000, 1);
    drain();
    // Asynchronous reset in the middle of traffic.
    for (int c = 0; c < N; c++) en_rate[c] = 100;
    repeat (7) step();
    #2 rst_n = 0;
    #1;
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_tdata", m_tdata, 0);
    check("rst_mid_tlast", m_tlast, 0);
    check("rst_mid_tuser", m_tuser, 0);
    check("rst_mid_tready", tready, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    en_rate[3] = 100;
    en_rate[5] = 100;
    mrate = 100;
    step();
    check("first_grant", tready, 6'h08);
    drain();
    // Fixed priority: highest index wins and holds through a mid-packet bubble.
    f_m_tready = 1;
    @(negedge clk);
    f_tvalid = 6'b010010;
    f_tdata[4*DW +: DW] = 32'hC0DE0004;
    f_tuser[4*UW +: UW] = 8'hA5;
    f_tdata[1*DW +: DW] = 32'h00001111;
    f_tuser[1*UW +: UW] = 8'h11;
    f_tlast = '0;
    #1 check("fp_prio", f_tready, 6'h10);
    @(negedge clk);
    f_tdata[4*DW +: DW] = 32'hC0DE0005;
    #1 check("fp_out_data", f_m_tdata, 32'hC0DE0004);
    check("fp_out_user", f_m_tuser, {8'hA5, 3'd4});
    check("fp_lock_1", f_tready, 6'h10);
    @(negedge clk);
    f_tvalid[4] = 0;
    #1 check("fp_bubble", f_tready, 6'h10);
    check("fp_out_data2", f_m_tdata, 32'hC0DE0005);
    @(negedge clk);
    f_tvalid[4] = 1;
    f_tlast[4] = 1;
    f_tdata[4*DW +: DW] = 32'hC0DE0006;
    #1 check("fp_lock_2", f_tready, 6'h10);
    @(negedge clk);
    f_tvalid[4] = 0;
    f_tlast = 6'b000010;
    #1 check("fp_next", f_tready, 6'h02);
    check("fp_out_last", f_m_tlast, 1);
    @(negedge clk);
    f_tvalid = '0;
    f_tlast = '0;
    #1 check("fp_out_tag", f_m_tuser, {8'h11, 3'd1});
    check("fp_out_valid", f_m_tvalid, 1);
`ifdef AXIS_ARB_MUX_TIMEOUT_EN
    m_tready = 1;
    @(negedge clk);
    tvalid = 6'b000100;
    tlast = '0;
    #1 check("to_grant", tready, 6'h04);
    @(negedge clk);
    tvalid = 6'b010000;
    repeat (7) @(negedge clk);
    #1 check("to_pre_err", err, 0);
    check("to_pre_rdy", tready, 6'h04);
    @(negedge clk);
    #1 check("to_err", err, 6'h04);
    check("to_regrant", tready, 6'h10);
`else
    check("no_timeout_err", err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_arb_mux.md
Name: axis_arb_mux

Overview:
- Next-generation AXI-stream N:1 arbiter/mux, successor to the fixed-priority fan-in.
- Adds selectable fixed-priority or round-robin arbitration, packet locking on tlast, and pass-through tuser alongside a binary channel tag.
- Output is a registered 2-entry skid stage: full throughput, no combinational ready path from master to slaves.
- Sits between per-antenna/per-core producers and a single shared DMA or packetiser stream in one clock domain.

Parameters:
- NUM_FANIN, 6: number of slave channels, 2..16.
- DATA_WIDTH, 256: tdata width per channel.
- USER_WIDTH, 8: per-channel tuser width passed through.
- CHAN_WIDTH, clog2(NUM_FANIN): width of the channel-tag field (derived).
- ARB_MODE, 1: 0 = fixed priority (highest index wins); 1 = round-robin.
- USE_AXIS_TLAST, 1: 1 = hold the grant until the tlast beat is accepted; 0 = re-arbitrate every beat.
- TIMEOUT_CYCLES, 1024: idle limit for the optional watchdog, must be ≥ 2.

Ports:
- s_axis_clk, in, 1: single clock.
- s_axis_rst_n, in, 1: reset, asynchronous and active-low.
- s_axis_tvalid, in, NUM_FANIN: per-channel valid.
- s_axis_tready, out, NUM_FANIN: per-channel ready; at most one bit high.
- s_axis_tdata, in, NUM_FANIN*DATA_WIDTH: packed data; channel n occupies [n*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast, in, NUM_FANIN: per-channel last.
- s_axis_tuser, in, NUM_FANIN*USER_WIDTH: packed user field.
- m_axis_tvalid, out, 1: output valid.
- m_axis_tready, in, 1: output ready.
- m_axis_tdata, out, DATA_WIDTH: output data.
- m_axis_tlast, out, 1: output last.
- m_axis_tuser, out, USER_WIDTH+CHAN_WIDTH: {passed tuser, binary channel index}.
- arb_timeout_err, out, NUM_FANIN: sticky per-channel watchdog flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync release):
  - m_axis_tvalid = 0, m_axis_tdata/tlast/tuser = 0, s_axis_tready = 0.
  - State IDLE, rr_ptr = 0, skid stage empty, arb_timeout_err = 0.
- States:
  - IDLE: no grant held.
  - LOCK: grant held for channel gnt.
- Arbitration (IDLE, or each beat when USE_AXIS_TLAST = 0):
  - Mode 0: grant the highest-index channel with tvalid high.
  - Mode 1: grant the first valid channel searching upward from rr_ptr, wrapping NUM_FANIN-1 → 0.
  - Decision is combinational on the current tvalid vector.
- Accepted beat: s_axis_tready[gnt] && s_axis_tvalid[gnt].
- IDLE → LOCK: beat accepted with tlast = 0 and USE_AXIS_TLAST = 1.
- LOCK → IDLE: accepted beat has tlast = 1.
- Single-beat packet (tlast on the first beat): stays IDLE.
- Round-robin pointer: rr_ptr <= gnt+1 (mod NUM_FANIN) on the cycle the packet ends. With USE_AXIS_TLAST = 0 this is every accepted beat.
- Packet integrity: while in LOCK, other channels' tready stays 0 even if the locked channel deasserts tvalid mid-packet.
- Handshake: s_axis_tready[gnt] = skid stage not full. All other tready bits = 0. Nothing is granted if no tvalid is high.
- Skid stage:
  - Accepted beats enter the 2-entry buffer; latency is 1 cycle from acceptance to m_axis_tvalid.
  - Sustains 1 beat/cycle with m_axis_tready held high.
  - Full when 2 entries are held. Simultaneous push and pop when full is not possible, because ready was 0.
  - Simultaneous push and pop with 1 entry keeps the count at 1.
- Output: m_axis_tvalid stays high and m_axis_tdata/tlast/tuser stay stable until m_axis_tready. Never withdrawn.
- Tag: m_axis_tuser[CHAN_WIDTH-1:0] = granted index; the upper USER_WIDTH bits = s_axis_tuser of that channel.
- Reset mid-packet: all state clears; the partial packet is dropped and no tlast is synthesised.

Optional Feature:
- Macro: AXIS_ARB_MUX_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCK cycle where s_axis_tvalid[gnt] = 0, and clears on any accepted beat.
  - When the counter reaches TIMEOUT_CYCLES: force IDLE, advance rr_ptr, set arb_timeout_err[gnt] (sticky until reset). No beat is injected.
- Not defined: no counter; arb_timeout_err tied to 0; a lock is held indefinitely.

Test Plan:
- ARB_MODE = 1, channels 0, 2, 5 each continuously send 3-beat packets, m_axis_tready = 1 → output packet order 0, 2, 5, 0, 2, 5; tuser channel tag matches; 1 beat/cycle after a 1-cycle initial latency.
- ARB_MODE = 0, channels 1 and 4 valid → channel 4 wins; channel 1 starts mid-packet on 4 → stays blocked until 4's tlast, then wins.
- Locked channel 3 drops tvalid for 5 cycles mid-packet while channel 0 is valid → channel 0 tready stays 0; packet 3 completes intact.
- Random m_axis_tready (50%) over 1000 beats → no loss or duplication, output stable while stalled, scoreboard matches.
- Assert s_axis_rst_n low mid-packet → all outputs 0 in the same cycle (async); after release, the first grant goes to the lowest valid index ≥ 0.
- With AXIS_ARB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES = 8, channel 2 stalls mid-packet → after 8 idle cycles arb_timeout_err = 0x04 and the next valid channel is granted.
